osu_serial_tx: RTL and testbench
================================

# osu_serial_tx

Parallel-in, serial-out frame transmitter clocked on a single CLK. It produces the bit stream that a downstream DFF-based capture stage samples on posedge CLK. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first inside a start/stop frame, holding each bit for DIV clock cycles. It sits at the digital edge of the SoC, between the core's output register bank and the pad driver.

## Interface
- WIDTH, 8: data bits per frame; legal range 1..32.
- DIV, 4: CLK cycles per serial bit; legal range 1..256.
- CLK  input  1  clock; all state changes on posedge CLK.
- RST  input  1  synchronous, active-high reset, sampled on posedge CLK.
- DIN  input  WIDTH  parallel word; sampled only on an accept edge.
- DIN_VALID  input  1  producer has a word on DIN.
- DIN_READY  output  1  transmitter can accept; equals (state==IDLE) & ~RST.
- SOUT  output  1  serial line, registered; idle level 1.
- BUSY  output  1  registered; 1 whenever state != IDLE.

## Operation
- States: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
- Accept edge: a posedge CLK with RST=0, DIN_VALID=1 and DIN_READY=1.
- On an accept edge:
  - DIN loads into the shift register.
  - The bit counter clears.
  - The divider counter clears.
  - State goes to START; SOUT goes to 0; BUSY goes to 1.
- Divider counter: counts 0..DIV-1 and is $clog2(DIV) bits, minimum 1 bit. A bit boundary is the edge where the counter equals DIV-1. At that edge the counter wraps to 0 and the next bit is driven.
- START→DATA at its bit boundary. SOUT becomes shreg[0].
- DATA: at each bit boundary the shift register shifts right and the bit counter increments.
  - After bit WIDTH-1, the state goes to PARITY if PARITY_EN is compiled in, otherwise to STOP.
  - SOUT in STOP is 1.
- PARITY→STOP at its bit boundary. SOUT is the even parity of the accepted word, i.e. XOR of all bits.
- STOP→IDLE at its bit boundary. SOUT stays 1; BUSY goes to 0.
- No new word is accepted while not IDLE. DIN and DIN_VALID changes mid-frame have no effect.
- The producer may hold DIN_VALID high across frames. Each IDLE cycle with VALID=1 accepts exactly one word.
- Reset, at any point including mid-frame:
  - Next state is IDLE, with SOUT=1 and BUSY=0.
  - The shift register and both counters go to 0.
  - The frame in progress is dropped with no partial stop bit.
  - DIN_READY is 0 while RST=1, so no accept occurs on a reset edge.

## Timing
- Take the accept at edge k and let N = WIDTH+2, or WIDTH+3 with parity.
- Start bit: SOUT=0 for cycles k+1 .. k+DIV.
- Data bit i: SOUT holds it for DIV cycles starting after edge k+(1+i)·DIV.
- Parity bit, when present: follows the last data bit for DIV cycles.
- Stop bit: SOUT=1 for DIV cycles ending at edge k+N·DIV. At that edge the state is IDLE and BUSY=0.
- Earliest next accept is edge k+N·DIV+1. The line is therefore high for at least DIV+1 cycles between frames.
- DIV=1: every bit lasts one cycle and the divider is a constant boundary.
- DIN_READY is combinational from state and RST, so it has no added latency. SOUT and BUSY have one-cycle registered latency from the state transition.

## Configuration
- PARITY_EN defined:
  - The PARITY state exists.
  - One even-parity bit is sent between the last data bit and the stop bit.
  - Frame length is (WIDTH+3)·DIV.
- PARITY_EN undefined:
  - The PARITY state and its parity XOR logic are absent from the netlist.
  - Frame length is (WIDTH+2)·DIV.

## Test plan
- Reset: hold RST=1 for 3 edges with DIN_VALID=1 → SOUT=1, BUSY=0, DIN_READY=0 throughout. After release, DIN_READY=1 and the first accept occurs on the next edge.
- Single frame, WIDTH=8, DIV=4, no parity, DIN=0xA5 → SOUT per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. BUSY is 1 for exactly 40 cycles.
- Same frame with PARITY_EN, DIN=0xA5 → parity bit 0 inserted before the stop bit; 44 busy cycles. DIN=0x01 → parity bit 1.
- Back-to-back: DIN_VALID held high with 0x3C then 0xC3 → second start bit begins exactly 41 cycles after the first. DIN change mid-frame does not corrupt the first frame.
- Mid-frame reset: assert RST for 1 edge during data bit 3 → SOUT=1 on the next cycle and state is IDLE. The next accepted word 0xFF transmits cleanly.
- DIV=1, WIDTH=1, DIN=1 → SOUT sequence 0,1,1 over 3 cycles; DIN_READY reasserts on cycle 4.

Source files
------------

// File: rtl/osu_serial_tx.sv
// osu_serial_tx
//   Parallel-in, serial-out frame transmitter. A WIDTH-bit word is accepted
//   over a valid/ready handshake and sent LSB first between a start bit (0)
//   and a stop bit (1). Each bit is held for DIV clock cycles. The line
//   idles high.
//
//   Optional feature macro: PARITY_EN
//     defined   -> one even-parity bit (XOR of the word) is sent between
//                  the last data bit and the stop bit.
//     undefined -> no parity state and no parity logic.
//
// Parameters
//   WIDTH  data bits per frame (1..32)
//   DIV    clock cycles per serial bit (1..256)
//
// Ports
//   CLK        clock, all state changes on its rising edge
//   RST        synchronous active-high reset
//   DIN        parallel word, sampled only on an accept edge
//   DIN_VALID  producer has a word on DIN
//   DIN_READY  transmitter can accept (idle and not in reset)
//   SOUT       registered serial line output
//   BUSY       registered, high whenever a frame is in progress
module osu_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SOUT,
  output logic             BUSY
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bitcnt, bitcnt_nxt;
  logic [DW-1:0]    divcnt, divcnt_nxt;
  logic             sout_nxt, busy_nxt;
  logic             accept, bnd;
`ifdef PARITY_EN
  logic             par, par_nxt;
`endif

  assign DIN_READY = (state == IDLE) & ~RST;
  assign accept    = DIN_READY & DIN_VALID;
  // With DIV=1 the counter is a constant 0, so every edge is a boundary.
  assign bnd       = (divcnt == DIV_LAST);

  // State register (also holds the shift register, counters and the
  // registered line outputs)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      SOUT   <= 1'b1;
      BUSY   <= 1'b0;
`ifdef PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      divcnt <= divcnt_nxt;
      SOUT   <= sout_nxt;
      BUSY   <= busy_nxt;
`ifdef PARITY_EN
      par    <= par_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    divcnt_nxt = divcnt;
`ifdef PARITY_EN
    par_nxt    = par;
`endif
    if (state != IDLE) begin
      divcnt_nxt = bnd ? '0 : divcnt + DW'(1);
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = START;
          shreg_nxt  = DIN;
          bitcnt_nxt = '0;
          divcnt_nxt = '0;
`ifdef PARITY_EN
          // Parity is latched from the accepted word, since the shift
          // register no longer holds all bits once shifting starts.
          par_nxt    = ^DIN;
`endif
        end
      end
      START: begin
        if (bnd) state_nxt = DATA;
      end
      DATA: begin
        if (bnd) begin
          shreg_nxt  = shreg >> 1;
          bitcnt_nxt = bitcnt + CW'(1);
          if (bitcnt == BIT_LAST) begin
`ifdef PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bnd) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bnd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: line value for the state being entered, registered above.
  // In DATA the LSB of the next shift register value is the bit on the line.
  always_comb begin
    sout_nxt = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   sout_nxt = 1'b0;
      DATA:    sout_nxt = shreg_nxt[0];
`ifdef PARITY_EN
      PARITY:  sout_nxt = par_nxt;
`endif
      default: sout_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_osu_serial_tx.sv
module tb_osu_serial_tx;

  localparam int W0 = 8;
  localparam int D0 = 4;
  localparam int W1 = 1;
  localparam int D1 = 1;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        CLK;
  logic        rst  [2];
  logic        vld  [2];
  logic [31:0] din  [2];
  logic        rdy  [2];
  logic        sout [2];
  logic        busy [2];

  int n_chk  = 0;
  int n_fail = 0;
  int ecount = 0;
  bit chk_en = 0;

  // behavioural model state: frame active, accept edge index, accepted word
  bit          m_act [2];
  int          m_k   [2];
  logic [31:0] m_w   [2];

  logic obs [128];
  int   bcnt;

  osu_serial_tx #(.WIDTH(W0), .DIV(D0)) dut (
    .CLK(CLK), .RST(rst[0]), .DIN(din[0][W0-1:0]), .DIN_VALID(vld[0]),
    .DIN_READY(rdy[0]), .SOUT(sout[0]), .BUSY(busy[0]));

  osu_serial_tx #(.WIDTH(W1), .DIV(D1)) dut1 (
    .CLK(CLK), .RST(rst[1]), .DIN(din[1][W1-1:0]), .DIN_VALID(vld[1]),
    .DIN_READY(rdy[1]), .SOUT(sout[1]), .BUSY(busy[1]));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic int wd(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int dv(int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int flen(int i);
    return (wd(i) + 2 + PAR) * dv(i);
  endfunction

  // Frame bit b of a word: 0 start, 1..W data LSB first, optional parity, stop.
  function automatic logic fbit(int i, logic [31:0] w, int b);
    logic p;
    p = 1'b0;
    if (b == 0) return 1'b0;
    if (b <= wd(i)) return w[b-1];
    if (PAR == 1 && b == wd(i) + 1) begin
      for (int j = 0; j < wd(i); j++) p = p ^ w[j];
      return p;
    end
    return 1'b1;
  endfunction

  function automatic bit m_idle(int i, int e);
    return !m_act[i] || ((e - m_k[i]) >= flen(i));
  endfunction

  task automatic chk(input string nm, input logic got, input logic expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d)", nm, got, expv, ecount);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, expv, ecount);
    end
  endtask

  // Model update on every rising edge, from the inputs seen at that edge.
  initial begin
    forever begin
      @(posedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) m_act[i] = 0;
        else if (vld[i] && m_idle(i, ecount)) begin
          m_act[i] = 1;
          m_k[i]   = ecount + 1;
          m_w[i]   = din[i];
        end
      end
      ecount++;
    end
  end

  // Compare process: checks both DUTs shortly after every edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          logic es, eb, er;
          int   d;
          d = ecount - m_k[i];
          if (!m_idle(i, ecount)) begin
            es = fbit(i, m_w[i], d / dv(i));
            eb = 1'b1;
          end else begin
            es = 1'b1;
            eb = 1'b0;
          end
          er = m_idle(i, ecount) && !rst[i];
          chk($sformatf("model_sout%0d", i), sout[i], es);
          chk($sformatf("model_busy%0d", i), busy[i], eb);
          chk($sformatf("model_ready%0d", i), rdy[i], er);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Send one word on the 8-bit instance and record the line for 64 cycles.
  task automatic send_cap(input logic [31:0] w);
    vld[0] = 1'b1;
    din[0] = w;
    tick();
    vld[0] = 1'b0;
    din[0] = $urandom;
    bcnt = 0;
    for (int c = 0; c < 64; c++) begin
      obs[c] = sout[0];
      if (busy[0]) bcnt++;
      tick();
    end
  endtask

  task automatic cmp_pat(input string nm, input int pat[$]);
    for (int b = 0; b < pat.size(); b++)
      chk($sformatf("%s_bit%0d", nm, b), obs[b*D0], pat[b] != 0);
  endtask

  initial begin
    int pat_a5[$];
    int pat_ff[$];
    int idx;
    logic s0, s1, s2;
`ifdef PARITY_EN
    pat_a5 = '{0,1,0,1,0,0,1,0,1,0,1};
    pat_ff = '{0,1,1,1,1,1,1,1,1,0,1};
`else
    pat_a5 = '{0,1,0,1,0,0,1,0,1,1};
    pat_ff = '{0,1,1,1,1,1,1,1,1,1};
`endif
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0;
      m_k[i]   = 0;
      m_w[i]   = '0;
      rst[i]   = 1'b1;
      vld[i]   = 1'b1;
      din[i]   = 32'h5A;
    end

    // reset held for 3 edges with valid high
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_en = 1;
      chk("rst_sout", sout[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_ready", rdy[0], 1'b0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    vld[1] = 1'b0;
    #1;
    chk("ready_after_reset", rdy[0], 1'b1);

    // single frame 0xA5
    send_cap(32'hA5);
    cmp_pat("a5", pat_a5);
    chk_int("a5_busy_cycles", bcnt, (PAR == 1) ? 44 : 40);

`ifdef PARITY_EN
    send_cap(32'h01);
    chk("p01_parity", obs[9*D0], 1'b1);
    chk_int("p01_busy_cycles", bcnt, 44);
`endif

    // back-to-back with valid held high, DIN changed mid-frame
    vld[0] = 1'b1;
    din[0] = 32'h3C;
    tick();
    for (int c = 0; c < 100; c++) begin
      obs[c] = sout[0];
      if (c == 20) din[0] = $urandom;
      if (c == 30) din[0] = 32'hC3;
      if (c == (PAR == 1 ? 45 : 41)) vld[0] = 1'b0;
      tick();
    end
    idx = -1;
    for (int c = 99; c >= 40; c--) if (obs[c] == 1'b0 && obs[c-1] == 1'b1 && c <= 50) idx = c;
    chk_int("b2b_gap", idx, (PAR == 1) ? 45 : 41);
    chk("b2b_3c_bit2", obs[3*D0], 1'b1);
    chk("b2b_c3_bit0", obs[((PAR == 1) ? 45 : 41) + D0], 1'b1);

    // reset during data bit 3
    vld[0] = 1'b1;
    din[0] = $urandom;
    tick();
    vld[0] = 1'b0;
    repeat (17) tick();
    rst[0] = 1'b1;
    tick();
    chk("midrst_sout", sout[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    rst[0] = 1'b0;
    #1;
    chk("midrst_ready", rdy[0], 1'b1);
    send_cap(32'hFF);
    cmp_pat("ff", pat_ff);
    chk_int("ff_busy_cycles", bcnt, (PAR == 1) ? 44 : 40);

    // WIDTH=1, DIV=1 instance
    vld[1] = 1'b1;
    din[1] = 32'h1;
    tick();
    vld[1] = 1'b0;
    s0 = sout[1];
    tick();
    s1 = sout[1];
    tick();
    s2 = sout[1];
    chk("w1_sout0", s0, 1'b0);
    chk("w1_sout1", s1, 1'b1);
    chk("w1_sout2", s2, 1'b1);
    chk("w1_ready_busy", rdy[1], 1'b0);
    if (PAR == 1) tick();
    tick();
    chk("w1_ready_back", rdy[1], 1'b1);

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 99) == 0);
        vld[i] = ($urandom_range(0, 3) != 0);
        din[i] = $urandom;
      end
      tick();
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (60) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
